bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Shares the single-port on-chip BRAM between the instruction-fetch port and the data port of the core.
- Each transaction gets a registered request phase and a registered response phase.
- Simultaneous requests are arbitrated round-robin.
- Addresses outside the BRAM window are rejected with an error response and never reach the BRAM.

Parameters:
- bram_depth, 13, BRAM word-address width (BRAM holds 2^bram_depth 32-bit words)
- bram_base_addr, 32'h0, first byte address of the BRAM window (inclusive)
- bram_top_addr, 32'h8000, end of the BRAM window (exclusive)

Ports:
- reset  in  1  asynchronous, active-low
- clock  in  1  system clock
- imem_valid  in  1  instruction request; held high until imem_ready
- imem_addr  in  32  instruction byte address
- imem_ready  out  1  one-cycle response pulse
- imem_rdata  out  32  read data, valid while imem_ready=1
- imem_error  out  1  out-of-window error, valid while imem_ready=1
- dmem_valid  in  1  data request; held high until dmem_ready
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte enables; 0 = read
- dmem_ready  out  1  one-cycle response pulse
- dmem_rdata  out  32  read data (0 for writes)
- dmem_error  out  1  out-of-window error
- bram_valid  out  1  BRAM request; held until bram_ready
- bram_addr  out  bram_depth  word index
- bram_wdata  out  32  write data
- bram_wstrb  out  4  byte enables
- bram_ready  in  1  BRAM completion pulse
- bram_rdata  in  32  BRAM read data, valid with bram_ready

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-low (reset=0). On reset:
  - state=IDLE, last_grant=DATA
  - all ready/error/valid outputs 0
  - rdata, addr, wdata and wstrb outputs 0
- Reset mid-transaction: bram_valid drops immediately and any pending response is discarded. The BRAM must tolerate an abandoned request.
- States:
  - IDLE: sample imem_valid and dmem_valid.
    - Neither valid: stay in IDLE.
    - One valid: grant that port.
    - Both valid: grant the port other than last_grant. After reset the instruction port wins the first tie.
    - On a grant, set last_grant to the winner.
    - In-window request: register bram_addr=(addr-bram_base_addr)[bram_depth+1:2], bram_wdata and bram_wstrb (imem: wstrb=0), set bram_valid=1, go to ACCESS.
    - Out-of-window request: go to RESP with error pending; no BRAM access.
  - ACCESS: hold bram_valid and the registered fields stable until bram_ready=1.
    - On bram_ready: capture bram_rdata (forced to 0 if wstrb≠0), clear bram_valid, go to RESP.
  - RESP: for exactly one cycle, drive the granted port's ready=1 with its rdata/error. Go to IDLE. Clear ready and error the next cycle.
- Window check: in-window iff bram_base_addr <= addr < bram_top_addr, unsigned 32-bit compare. addr[1:0] is ignored (word access; byte lanes via wstrb). Out-of-window response: error=1, rdata=0.
- Latency (cycle N = first IDLE cycle seeing valid):
  - bram_valid goes high at N+1.
  - If bram_ready arrives in cycle M, port ready is high in M+1 and state is IDLE at M+2.
  - Zero-wait BRAM (bram_ready in N+1): ready at N+2, next grant sampled at N+3.
  - Error path: ready/error in N+1, IDLE at N+2.
- A requester drops valid in the cycle after ready. RESP→IDLE spacing guarantees the same request is never re-granted.
- The losing port's valid stays pending and is granted on the next IDLE. Round-robin bounds its wait to one transaction.
- Port outputs of the non-granted port stay 0.
- Inputs that change while not in IDLE are ignored; only the IDLE-cycle sample is used.

Test Plan:
- Single imem read of addr 0x10, BRAM word 4 = 0xDEADBEEF, bram_ready 1 cycle after bram_valid → bram_addr=4, imem_ready pulses 1 cycle with imem_rdata=0xDEADBEEF, imem_error=0.
- dmem write addr 0x4008, wdata 0x12345678, wstrb 4'b0011 → bram_addr=0x1002, bram_wstrb=0011; dmem_ready with dmem_rdata=0; a later read of 0x4008 returns the low half updated.
- imem and dmem valid in the same cycle, three times back to back → grants after reset are I, D, I, D, ... No port waits for more than one other transaction.
- dmem read of 0x1000000 (UART, outside window) → no bram_valid ever; dmem_ready=1, dmem_error=1, dmem_rdata=0 one cycle after sampling.
- bram_ready delayed 5 cycles → bram_valid, bram_addr and bram_wstrb stable for all 5 cycles; a single response pulse follows.
- reset asserted while in ACCESS → bram_valid=0 and all outputs 0 asynchronously; after release, a new imem request completes normally.

Source files
------------

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between instruction fetch and data ports.
// Latency: grant+request register 1 cycle, response registered 1 cycle after bram_ready; requesters hold valid until ready.
module bram_arbiter #(
    parameter int          bram_depth     = 13,
    parameter logic [31:0] bram_base_addr = 32'h0,
    parameter logic [31:0] bram_top_addr  = 32'h8000
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_addr,
    output logic                  imem_ready,
    output logic [31:0]           imem_rdata,
    output logic                  imem_error,
    input  logic                  dmem_valid,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_wdata,
    input  logic [3:0]            dmem_wstrb,
    output logic                  dmem_ready,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_error,
    output logic                  bram_valid,
    output logic [bram_depth-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    output logic [3:0]            bram_wstrb,
    input  logic                  bram_ready,
    input  logic [31:0]           bram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;   // 1 = data port won last
    logic                  grant_q;        // 1 = data port owns the current transaction
    logic                  bram_valid_q;
    logic [bram_depth-1:0] bram_addr_q;
    logic [31:0]           bram_wdata_q;
    logic [3:0]            bram_wstrb_q;
    logic                  imem_ready_q;
    logic [31:0]           imem_rdata_q;
    logic                  imem_error_q;
    logic                  dmem_ready_q;
    logic [31:0]           dmem_rdata_q;
    logic                  dmem_error_q;

    logic                  pick_dmem_d;
    logic [31:0]           req_addr_d;
    logic [31:0]           req_wdata_d;
    logic [3:0]            req_wstrb_d;
    logic [31:0]           req_word_d;
    logic                  req_in_win_d;
    logic [bram_depth-1:0] req_index_d;

    // The data port wins only when alone or when fetch had the previous grant.
    always_comb begin
        pick_dmem_d  = dmem_valid && (!imem_valid || !last_grant_q);
        req_addr_d   = pick_dmem_d ? dmem_addr  : imem_addr;
        req_wdata_d  = pick_dmem_d ? dmem_wdata : 32'h0;
        req_wstrb_d  = pick_dmem_d ? dmem_wstrb : 4'h0;
        req_word_d   = req_addr_d & ~32'h3;
        req_in_win_d = (req_word_d >= bram_base_addr) && (req_word_d < bram_top_addr);
        req_index_d  = bram_depth'((req_word_d - bram_base_addr) >> 2);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            bram_valid_q <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            bram_wstrb_q <= '0;
            imem_ready_q <= 1'b0;
            imem_rdata_q <= '0;
            imem_error_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (imem_valid || dmem_valid) begin
                        grant_q      <= pick_dmem_d;
                        last_grant_q <= pick_dmem_d;
                        if (req_in_win_d) begin
                            bram_valid_q <= 1'b1;
                            bram_addr_q  <= req_index_d;
                            bram_wdata_q <= req_wdata_d;
                            bram_wstrb_q <= req_wstrb_d;
                            state_q      <= ST_ACCESS;
                        end else begin
                            // Out-of-window: answer directly, BRAM untouched.
                            if (pick_dmem_d) begin
                                dmem_ready_q <= 1'b1;
                                dmem_error_q <= 1'b1;
                            end else begin
                                imem_ready_q <= 1'b1;
                                imem_error_q <= 1'b1;
                            end
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bram_ready) begin
                        bram_valid_q <= 1'b0;
                        state_q      <= ST_RESP;
                        if (grant_q) begin
                            dmem_ready_q <= 1'b1;
                            dmem_rdata_q <= (bram_wstrb_q != 4'h0) ? 32'h0 : bram_rdata;
                        end else begin
                            imem_ready_q <= 1'b1;
                            imem_rdata_q <= bram_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    imem_ready_q <= 1'b0;
                    imem_rdata_q <= '0;
                    imem_error_q <= 1'b0;
                    dmem_ready_q <= 1'b0;
                    dmem_rdata_q <= '0;
                    dmem_error_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bram_valid = bram_valid_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_wstrb = bram_wstrb_q;
    assign imem_ready = imem_ready_q;
    assign imem_rdata = imem_rdata_q;
    assign imem_error = imem_error_q;
    assign dmem_ready = dmem_ready_q;
    assign dmem_rdata = dmem_rdata_q;
    assign dmem_error = dmem_error_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized and directed bench for bram_arbiter with a memory-level reference model.
module tb_bram_arbiter;

    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] TOP  = 32'h8000;

    logic        reset, clock;
    logic        imem_valid, imem_ready, imem_error;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_valid, dmem_ready, dmem_error;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        bram_valid, bram_ready;
    logic [12:0] bram_addr;
    logic [31:0] bram_wdata, bram_rdata;
    logic [3:0]  bram_wstrb;

    bram_arbiter dut (
        .reset(reset), .clock(clock),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_error(dmem_error),
        .bram_valid(bram_valid), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_wstrb(bram_wstrb), .bram_ready(bram_ready), .bram_rdata(bram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] bram_mem [0:8191];
    logic [31:0] ref_mem  [0:8191];

    int n_tests = 0, n_fail = 0, cyc = 0;
    bit rand_on = 0;
    int fixed_lat = 1;
    // BRAM responder state
    bit b_busy = 0;
    int b_wait, b_lat, b_hi, last_hi;
    logic [12:0] b_addr, rise_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wstrb, rise_wstrb;
    int bram_rise_cnt = 0, bram_rise_cyc = 0;
    // requester state
    bit i_pend = 0, d_pend = 0;
    logic [31:0] i_addr_r, d_addr_r, d_wdata_r;
    logic [3:0]  d_wstrb_r;
    int i_age, d_age, i_others, d_others;
    int imem_cnt = 0, dmem_cnt = 0, i_ready_cyc = 0, d_ready_cyc = 0;
    logic [31:0] last_i_rdata, last_d_rdata;
    logic last_i_err, last_d_err;
    int order_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] w = a & ~32'h3;
        return (w >= BASE) && (w < TOP);
    endfunction

    function automatic logic [12:0] widx(input logic [31:0] a);
        return 13'(((a & ~32'h3) - BASE) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic bit req_match();
        bit m = 0;
        if (i_pend && in_win(i_addr_r) && bram_addr == widx(i_addr_r) &&
            bram_wstrb == 4'h0 && bram_wdata == 32'h0) m = 1;
        if (d_pend && in_win(d_addr_r) && bram_addr == widx(d_addr_r) &&
            bram_wstrb == d_wstrb_r && bram_wdata == d_wdata_r) m = 1;
        return m;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000 + 32'($urandom_range(0, 255));
        if (r == 1) return $urandom | 32'h0001_0000;
        if (r == 2) return 32'h7FFC + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    task automatic issue_i(input logic [31:0] a);
        imem_addr = a; imem_valid = 1'b1; i_addr_r = a;
        i_pend = 1; i_age = 0; i_others = 0;
    endtask

    task automatic issue_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws; dmem_valid = 1'b1;
        d_addr_r = a; d_wdata_r = wd; d_wstrb_r = ws;
        d_pend = 1; d_age = 0; d_others = 0;
    endtask

    task automatic step();
        logic [31:0] exp_r;
        logic [12:0] ix;
        @(posedge clock); #1;
        cyc++;
        bram_ready = 1'b0;
        // BRAM model with configurable wait states
        if (bram_valid) begin
            if (!b_busy) begin
                b_busy = 1; b_wait = 0; b_hi = 0;
                b_addr = bram_addr; b_wdata = bram_wdata; b_wstrb = bram_wstrb;
                rise_addr = bram_addr; rise_wstrb = bram_wstrb;
                bram_rise_cnt++; bram_rise_cyc = cyc;
                b_lat = rand_on ? $urandom_range(0, 3) : fixed_lat;
                chk("bram_req", 32'(req_match()), 32'd1);
            end else begin
                chk("bram_hold_addr", 32'(bram_addr), 32'(b_addr));
                chk("bram_hold_wstrb", 32'(bram_wstrb), 32'(b_wstrb));
                chk("bram_hold_wdata", bram_wdata, b_wdata);
            end
            b_hi++;
            if (b_wait == b_lat) begin
                bram_ready = 1'b1;
                bram_rdata = bram_mem[bram_addr];
                bram_mem[bram_addr] = merge(bram_mem[bram_addr], bram_wdata, bram_wstrb);
                b_busy = 0; last_hi = b_hi;
            end else begin
                b_wait++;
                bram_rdata = $urandom;
            end
        end else begin
            b_busy = 0;
            bram_rdata = $urandom;
        end
        chk("dual_ready", 32'(imem_ready && dmem_ready), 32'd0);
        if (imem_ready) begin
            chk("imem_spurious", 32'(i_pend), 32'd1);
            if (i_pend) begin
                exp_r = in_win(i_addr_r) ? ref_mem[widx(i_addr_r)] : 32'h0;
                chk("imem_err", 32'(imem_error), 32'(!in_win(i_addr_r)));
                chk("imem_rdata", imem_rdata, exp_r);
                chk("imem_fair", 32'(i_others > 1), 32'd0);
                last_i_rdata = imem_rdata; last_i_err = imem_error;
                imem_cnt++; i_ready_cyc = cyc; order_q.push_back(0);
                i_pend = 0; imem_valid = 1'b0;
                if (d_pend) d_others++;
            end
        end else begin
            chk("imem_idle_err", 32'(imem_error), 32'd0);
            if (dmem_ready) chk("imem_idle_rdata", imem_rdata, 32'h0);
        end
        if (dmem_ready) begin
            chk("dmem_spurious", 32'(d_pend), 32'd1);
            if (d_pend) begin
                exp_r = 32'h0;
                if (in_win(d_addr_r)) begin
                    ix = widx(d_addr_r);
                    if (d_wstrb_r == 4'h0) exp_r = ref_mem[ix];
                    else ref_mem[ix] = merge(ref_mem[ix], d_wdata_r, d_wstrb_r);
                end
                chk("dmem_err", 32'(dmem_error), 32'(!in_win(d_addr_r)));
                chk("dmem_rdata", dmem_rdata, exp_r);
                chk("dmem_fair", 32'(d_others > 1), 32'd0);
                last_d_rdata = dmem_rdata; last_d_err = dmem_error;
                dmem_cnt++; d_ready_cyc = cyc; order_q.push_back(1);
                d_pend = 0; dmem_valid = 1'b0;
                if (i_pend) i_others++;
            end
        end else begin
            chk("dmem_idle_err", 32'(dmem_error), 32'd0);
            if (imem_ready) chk("dmem_idle_rdata", dmem_rdata, 32'h0);
        end
        if (i_pend && ++i_age > 60) begin
            chk("imem_timeout", 32'(i_age), 32'd60);
            i_pend = 0; imem_valid = 1'b0;
        end
        if (d_pend && ++d_age > 60) begin
            chk("dmem_timeout", 32'(d_age), 32'd60);
            d_pend = 0; dmem_valid = 1'b0;
        end
        if (rand_on) begin
            if (!i_pend && $urandom_range(0, 2) == 0) issue_i(rand_addr());
            if (!d_pend && $urandom_range(0, 2) == 0)
                issue_d(rand_addr(), $urandom,
                        ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
        end
    endtask

    task automatic wait_i();
        int n = imem_cnt;
        for (int k = 0; k < 40; k++) begin
            step();
            if (imem_cnt != n) break;
        end
        chk("wait_imem", 32'(imem_cnt), 32'(n + 1));
    endtask

    task automatic wait_d();
        int n = dmem_cnt;
        for (int k = 0; k < 40; k++) begin
            step();
            if (dmem_cnt != n) break;
        end
        chk("wait_dmem", 32'(dmem_cnt), 32'(n + 1));
    endtask

    task automatic check_zero(input string p);
        chk({p, "_bram_valid"}, 32'(bram_valid), 32'd0);
        chk({p, "_bram_addr"}, 32'(bram_addr), 32'd0);
        chk({p, "_bram_wdata"}, bram_wdata, 32'd0);
        chk({p, "_bram_wstrb"}, 32'(bram_wstrb), 32'd0);
        chk({p, "_imem_ready"}, 32'(imem_ready), 32'd0);
        chk({p, "_imem_rdata"}, imem_rdata, 32'd0);
        chk({p, "_imem_error"}, 32'(imem_error), 32'd0);
        chk({p, "_dmem_ready"}, 32'(dmem_ready), 32'd0);
        chk({p, "_dmem_rdata"}, dmem_rdata, 32'd0);
        chk({p, "_dmem_error"}, 32'(dmem_error), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_valid = 1'b0; dmem_valid = 1'b0; i_pend = 0; d_pend = 0;
        repeat (3) step();
        check_zero("rst");
        reset = 1'b1;
        step();
        order_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, ni, nd;
        logic [31:0] orig;
        reset = 1'b0; imem_valid = 1'b0; imem_addr = '0;
        dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        bram_ready = 1'b0; bram_rdata = '0;
        for (int k = 0; k < 8192; k++) begin
            bram_mem[k] = $urandom;
            ref_mem[k]  = bram_mem[k];
        end
        bram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        do_reset();

        // single fetch, one wait state
        fixed_lat = 1;
        t0 = cyc;
        issue_i(32'h10);
        wait_i();
        chk("t1_bram_rise", 32'(bram_rise_cyc - t0), 32'd1);
        chk("t1_bram_addr", 32'(rise_addr), 32'd4);
        chk("t1_latency", 32'(i_ready_cyc - t0), 32'd3);
        chk("t1_rdata", last_i_rdata, 32'hDEADBEEF);
        step();
        chk("t1_pulse", 32'(imem_ready), 32'd0);

        // partial write then read back
        orig = ref_mem[13'h1002];
        issue_d(32'h4008, 32'h12345678, 4'b0011);
        wait_d();
        chk("t2_bram_addr", 32'(rise_addr), 32'h1002);
        chk("t2_bram_wstrb", 32'(rise_wstrb), 32'b0011);
        chk("t2_wr_rdata", last_d_rdata, 32'h0);
        step();
        issue_d(32'h4008, 32'h0, 4'h0);
        wait_d();
        chk("t2_readback", last_d_rdata, {orig[31:16], 16'h5678});

        // back-to-back ties alternate starting with fetch
        do_reset();
        fixed_lat = 0;
        issue_i(32'h20); issue_d(32'h24, 32'h0, 4'h0);
        ni = 1; nd = 1;
        for (int k = 0; k < 80 && order_q.size() < 6; k++) begin
            step();
            if (!i_pend && ni < 3) begin issue_i(32'($urandom_range(0, 63)) * 4); ni++; end
            if (!d_pend && nd < 3) begin issue_d(32'($urandom_range(0, 63)) * 4, 32'h0, 4'h0); nd++; end
        end
        chk("t3_count", 32'(order_q.size()), 32'd6);
        for (int k = 0; k < order_q.size() && k < 6; k++)
            chk("t3_order", 32'(order_q[k]), 32'(k % 2));

        // out-of-window access never reaches the BRAM
        step();
        n = bram_rise_cnt; t0 = cyc;
        issue_d(32'h0100_0000, 32'h0, 4'h0);
        wait_d();
        step();
        chk("t4_latency", 32'(d_ready_cyc - t0), 32'd1);
        chk("t4_no_bram", 32'(bram_rise_cnt), 32'(n));
        chk("t4_error", 32'(last_d_err), 32'd1);
        chk("t4_rdata", last_d_rdata, 32'h0);

        // five wait states: request held steady, single pulse
        fixed_lat = 5;
        n = dmem_cnt; t0 = cyc;
        issue_d(32'h20, 32'h0, 4'h0);
        wait_d();
        repeat (4) step();
        chk("t5_latency", 32'(d_ready_cyc - t0), 32'd7);
        chk("t5_hold", 32'(last_hi), 32'd6);
        chk("t5_pulses", 32'(dmem_cnt), 32'(n + 1));

        // reset while the BRAM access is outstanding
        issue_i(32'h40);
        repeat (3) step();
        chk("t6_in_access", 32'(bram_valid), 32'd1);
        #2 reset = 1'b0;
        #1 check_zero("t6_async");
        imem_valid = 1'b0; i_pend = 0;
        repeat (2) step();
        reset = 1'b1;
        step();
        fixed_lat = 1;
        n = imem_cnt;
        issue_i(32'h44);
        wait_i();
        chk("t6_after_err", 32'(last_i_err), 32'd0);
        chk("t6_after_cnt", 32'(imem_cnt), 32'(n + 1));

        // random mixed traffic
        rand_on = 1;
        repeat (2000) step();
        rand_on = 0;
        for (int k = 0; k < 100 && (i_pend || d_pend); k++) step();
        chk("drain", 32'(i_pend || d_pend), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
